// File: rtl/isa_dma_pkg.sv
// isa_dma_pkg: shared types, widths and helpers for the ISA DMA arbiter
package isa_dma_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int CNT_W = 16;
  localparam int TMR_W = 16;
  typedef enum logic [2:0] {IDLE, PIO, DMA_SETUP, DMA_XFER, DMA_RELEASE} state_t;
  typedef enum logic {KIND_PIO, KIND_DMA} kind_t;
  function automatic logic [CH_W-1:0] oh2idx(input logic [NUM_CH-1:0] oh);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) if (oh[i]) idx = CH_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/isa_rr_arbiter.sv
// isa_rr_arbiter: round-robin one-hot selector over NUM_CH requests
//   req   - eligible channels
//   ptr   - round-robin pointer; the channel after the last one serviced,
//           which therefore has highest priority (0 after reset)
//   grant - one-hot grant, all zero when nothing requests
module isa_rr_arbiter
  import isa_dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant
);
  // Scan from lowest to highest priority so the highest-priority hit lands last.
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[ptr + CH_W'(i)]) grant = NUM_CH'(1) << (ptr + CH_W'(i));
  end
endmodule

// File: rtl/isa_dma_arbiter.sv
// isa_dma_arbiter: ISA bus ownership arbiter between HPS PIO cycles and four DMA channels
//   drq/ch_enable/cnt_load/cnt_value - channel requests, enables and transfer-count loads
//   pio_req/pio_done/pio_grant       - HPS I/O cycle handshake
//   dma_start/dma_done               - datapath transfer handshake
//   dack_n/aen/tc/dma_err/busy       - ISA acknowledges, address enable, status pulses
module isa_dma_arbiter
  import isa_dma_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] drq,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] cnt_load,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic              pio_req,
  input  logic              pio_done,
  output logic              pio_grant,
  output logic              dma_start,
  input  logic              dma_done,
  output logic [NUM_CH-1:0] dack_n,
  output logic              aen,
  output logic [NUM_CH-1:0] tc,
  output logic              dma_err,
  output logic              busy
);
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0] cnt_nz, eligible, grant;
  logic [CH_W-1:0] rr_ptr, ch, sel_idx;
  logic [TMR_W-1:0] timer;
  state_t state;
  kind_t last_kind;
  always_ff @(posedge clk)
    sync_q <= reset ? '0 : {sync_q[SYNC_STAGES-2:0], drq};
  always_comb
    for (int c = 0; c < NUM_CH; c++) cnt_nz[c] = cnt[c] != '0;
  assign eligible = sync_q[SYNC_STAGES-1] & ch_enable & cnt_nz;
  assign sel_idx = oh2idx(grant);
  isa_rr_arbiter u_rr (.req(eligible), .ptr(rr_ptr), .grant(grant));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_kind <= KIND_PIO;
      rr_ptr <= '0;
      ch <= '0;
      timer <= '0;
      cnt <= '0;
      pio_grant <= 1'b0;
      dma_start <= 1'b0;
      dack_n <= '1;
      aen <= 1'b0;
      tc <= '0;
      dma_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      dma_start <= 1'b0;
      tc <= '0;
      case (state)
        IDLE:
          if (|eligible && (!pio_req || last_kind == KIND_PIO)) begin
            state <= DMA_SETUP;
            ch <= sel_idx;
            rr_ptr <= sel_idx + CH_W'(1);
            last_kind <= KIND_DMA;
            dack_n <= ~grant;
            aen <= 1'b1;
            busy <= 1'b1;
          end else if (pio_req) begin
            state <= PIO;
            last_kind <= KIND_PIO;
            pio_grant <= 1'b1;
            busy <= 1'b1;
          end
        PIO:
          if (pio_done) begin
            state <= IDLE;
            pio_grant <= 1'b0;
            busy <= 1'b0;
          end
        DMA_SETUP: begin
          state <= DMA_XFER;
          dma_start <= 1'b1;
          timer <= '0;
        end
        DMA_XFER: begin
          timer <= timer + TMR_W'(1);
          // dma_err is raised one cycle before leaving so it marks the timeout cycle itself
          if (dma_err) begin
            state <= DMA_RELEASE;
            dma_err <= 1'b0;
          end else if (dma_done) begin
            state <= DMA_RELEASE;
            // a simultaneous load of this channel wins over the decrement
            if (!cnt_load[ch] && cnt_nz[ch]) begin
              cnt[ch] <= cnt[ch] - CNT_W'(1);
              tc[ch] <= cnt[ch] == CNT_W'(1);
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) dma_err <= 1'b1;
        end
        DMA_RELEASE: begin
          state <= IDLE;
          dack_n <= '1;
          aen <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      for (int c = 0; c < NUM_CH; c++) if (cnt_load[c]) cnt[c] <= cnt_value;
    end
  end
endmodule

// File: doc/isa_dma_arbiter.md
ISA_DMA_ARBITER -- requirements
Module: isa_dma_arbiter

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flip-flop stages synchronising each DRQ input (minimum 2).
REQ-002 Parameter: TIMEOUT, 255, maximum cycles to wait for dma_done before aborting a DMA cycle.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 Port: clk  in  1  system clock; all logic is rising-edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: drq  in  4  asynchronous ISA DMA requests, active-high; bit 0..3 = DRQ1, DRQ3, DRQ5, DRQ7.
REQ-007 Port: ch_enable  in  4  per-channel enable written by the HPS register file.
REQ-008 Port: cnt_load  in  4  one-cycle strobe; loads cnt_value into the selected channel counter.
REQ-009 Port: cnt_value  in  16  transfer count to load; 0 means the channel is inactive.
REQ-010 Port: pio_req  in  1  HPS I/O cycle request; level, held until pio_done.
REQ-011 Port: pio_done  in  1  one-cycle pulse from the bus state machine ending a PIO cycle.
REQ-012 Port: pio_grant  out  1  the HPS owns the ISA bus.
REQ-013 Port: dma_start  out  1  one-cycle pulse telling the datapath to run a DMA transfer.
REQ-014 Port: dma_done  in  1  one-cycle pulse from the datapath ending a DMA transfer.
REQ-015 Port: dack_n  out  4  ISA DMA acknowledges, active-low, one-hot-low.
REQ-016 Port: aen  out  1  ISA address enable; high during DMA ownership.
REQ-017 Port: tc  out  4  one-cycle terminal-count pulse per channel.
REQ-018 Port: dma_err  out  1  one-cycle pulse on a DMA timeout.
REQ-019 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-020 Each drq bit SHALL pass through SYNC_STAGES flip-flops; only synchronised values are used.
REQ-021 A channel is eligible only when: synchronised drq = 1, ch_enable = 1 and its counter is non-zero.
REQ-022 FSM states: IDLE, PIO, DMA_SETUP, DMA_XFER, DMA_RELEASE.
REQ-023 IDLE transitions:
  - to DMA_SETUP when any channel is eligible;
  - to PIO when pio_req is high;
  - when both apply, the opposite of the last granted kind (DMA or PIO) wins; after reset, DMA wins.
REQ-024 Channel selection among eligible channels SHALL be round-robin, starting after the last serviced channel; after reset, channel 0 has highest priority.
REQ-025 PIO: pio_grant = 1 for the whole state; on pio_done, go to IDLE and drop pio_grant on the next cycle.
REQ-026 DMA_SETUP (1 cycle): the selected dack_n bit = 0 and aen = 1; the selected channel is latched for the whole transaction.
REQ-027 DMA_XFER: dma_start = 1 on the first cycle only; dack_n and aen are held; wait for dma_done.
REQ-028 On dma_done: decrement the channel counter by 1 and go to DMA_RELEASE.
REQ-029 If the counter reaches 0 on that decrement: pulse tc for that channel in the same cycle.
REQ-030 DMA_RELEASE (1 cycle): dack_n and aen are held, then IDLE; in IDLE, dack_n = 4'hF and aen = 0.
REQ-031 Latency: eligible in IDLE at cycle N -> dack_n low at N+1 -> dma_start at N+2.
REQ-032 Timeout: if dma_done has not arrived TIMEOUT cycles after dma_start, pulse dma_err, leave the counter unchanged and go to DMA_RELEASE.
REQ-033 drq dropping during DMA_SETUP or DMA_XFER SHALL NOT abort the transfer.
REQ-034 cnt_load and dma_done on the same channel in the same cycle: the load wins, with no decrement and no tc.
REQ-035 Clearing ch_enable mid-transfer SHALL NOT abort the transfer; it blocks the next grant.
REQ-036 dma_done or pio_done arriving in a state that does not expect it SHALL be ignored.
REQ-037 At most one dack_n bit is low at any time; pio_grant and aen are never high together.

Reset
REQ-038 While reset is high at a clock edge, the FSM SHALL go to IDLE, including mid-transfer.
REQ-039 Reset values: dack_n = 4'hF; aen, pio_grant, dma_start, tc, dma_err and busy = 0.
REQ-040 Reset values: all counters and synchroniser flops = 0; round-robin pointer = channel 0; last-kind = PIO.

Structure
REQ-041 Package isa_dma_pkg SHALL hold:
  - the FSM state enum;
  - NUM_CH = 4;
  - the counter width (16);
  - the timeout counter width.
REQ-042 The round-robin selector SHALL be a sub-module, isa_rr_arbiter: 4 requests, a last-grant pointer, and a one-hot grant output.

Verification
REQ-043 Single DMA: load ch1 with count 2, enable it, raise drq[1] -> two dack_n = 4'b1101 transactions, dma_start each, tc[1] on the second dma_done; no third grant.
REQ-044 Round-robin: all four channels eligible with count 1 -> grants in order 0, 1, 2, 3, each with a single tc.
REQ-045 PIO/DMA alternation: pio_req and drq[0] asserted together from reset -> DMA first, then PIO, with pio_grant and aen never overlapping.
REQ-046 Timeout: withhold dma_done -> dma_err exactly TIMEOUT cycles after dma_start, counter unchanged, dack_n = 4'hF two cycles later.
REQ-047 Collision and reset: cnt_load of 5 in the same cycle as dma_done -> counter = 5, no tc; reset asserted in DMA_XFER -> all outputs at reset values after the next edge.
